uart_rx: RTL

Parametrised asynchronous serial receiver: the next generation of the fixed 8N1 RS-232 receiver used on the 12 MHz boards. It adds configurable baud, data width, parity and stop bits; 16× oversampling with majority vote; false-start rejection; per-word error flags; break handling; and a small output FIFO with a valid/ready handshake. It sits between the board RX pin and any byte consumer (LED control, command parser).

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_fifo.sv | 57 +++++
 rtl/uart_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2,
        BREAK
    } rx_state_t;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with valid/ready read side; write lands on the push edge, visible next cycle.
// Push while full is accepted only when the head is popped in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             do_rd;
    logic             do_wr;

    // Extra MSB separates full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_rdy && !empty;
    assign do_wr = wr_vld && (!full || do_rd);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rd_vld = !empty;
    assign rd_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with majority vote, false-start rejection, break handling and output FIFO.
// Word is written on the final stop decision edge, valid next cycle; a full FIFO without pop drops it and pulses overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int KW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int FW  = DATA_BITS + 2;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [KW-1:0] K_S0     = KW'(OVERSAMPLE / 2 - 1);
    localparam logic [KW-1:0] K_S1     = KW'(OVERSAMPLE / 2);
    localparam logic [KW-1:0] K_DEC    = KW'(OVERSAMPLE / 2 + 1);
    localparam logic [KW-1:0] K_LAST   = KW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_rx: clock too slow for BAUD*OVERSAMPLE (DIV < 2)");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_rx: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
        $error("uart_rx: PARITY must be 0..2 and STOP_BITS 1..2");
    end

    rx_state_t             state, state_nxt;
    logic                  rx_meta, rx_s, rx_d;
    logic [2:0]            sync_ok;
    logic                  start_edge;
    logic [DW-1:0]         div_cnt;
    logic [KW-1:0]         k;
    logic                  tick;
    logic                  decide;
    logic                  s0, s1, maj;
    logic [DATA_BITS-1:0]  shreg;
    logic [BW-1:0]         bit_cnt;
    logic                  par_err;
    logic                  stop_err;
    logic                  shift_en, par_chk, stop1_chk, push;
    logic                  fifo_full;
    logic [FW-1:0]         head;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
            sync_ok <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
            sync_ok <= {sync_ok[1:0], 1'b1};
        end
    end

    // Edges are ignored until the synchroniser holds real line samples, so a line low at reset release is not a start.
    assign start_edge = sync_ok[2] && rx_d && !rx_s;

    assign tick   = (state != IDLE) && (div_cnt == DIV_LAST);
    assign decide = tick && (k == K_DEC);
    assign maj    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            k       <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
        end else begin
            if (state == IDLE) begin
                div_cnt <= '0;
                k       <= '0;
            end else if (tick) begin
                div_cnt <= '0;
                k       <= (k == K_LAST) ? '0 : k + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (tick && k == K_S0) s0 <= rx_s;
            if (tick && k == K_S1) s1 <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transitions happen at the decision tick; the next state samples the following bit's centre.
    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop1_chk = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) state_nxt = START;
            end
            START: begin
                if (decide) state_nxt = maj ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (decide) begin
                    par_chk   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (STOP_BITS == 2) begin
                        stop1_chk = 1'b1;
                        state_nxt = STOP2;
                    end else begin
                        push      = 1'b1;
                        state_nxt = maj ? IDLE : BREAK;
                    end
                end
            end
            STOP2: begin
                if (decide) begin
                    push      = 1'b1;
                    state_nxt = maj ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            par_err  <= 1'b0;
            stop_err <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (state == IDLE && start_edge) begin
                shreg    <= '0;
                bit_cnt  <= '0;
                par_err  <= 1'b0;
                stop_err <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {maj, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_chk) begin
                par_err <= maj ^ ((PARITY == PAR_ODD) ? ~^shreg : ^shreg);
            end
            if (stop1_chk) begin
                stop_err <= ~maj;
            end
            overrun <= push && fifo_full && !ready;
        end
    end

    uart_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_vld (push),
        .wr_dat ({par_err, stop_err | ~maj, shreg}),
        .full   (fifo_full),
        .rd_vld (valid),
        .rd_dat (head),
        .rd_rdy (ready)
    );

    assign {parity_err, frame_err, data} = head;
    assign busy = (state != IDLE);

endmodule
